// File: rtl/pipeline_exec_ctrl_pkg.sv
// Shared pipeline control encodings: latch modes, debug commands, controller states,
// plus the per-state output decode used by the execution controller.
package pipeline_ctrl_pkg;

    localparam logic [1:0] FREEZE_MOD = 2'b00;
    localparam logic [1:0] CONT_MOD   = 2'b01;
    localparam logic [1:0] STEP_MOD   = 2'b11;

    localparam int NB_DRAIN = 4;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_HALT = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_DUMP = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef struct packed {
        logic [1:0] mode;
        logic       execute;
        logic       dump_req;
        logic       done;
        logic       cmd_ready;
    } ctrl_out_t;

    // Outputs are loaded together with the state so they come straight off flops.
    function automatic ctrl_out_t state_outputs(state_e st);
        ctrl_out_t o;
        o = '{mode: FREEZE_MOD, execute: 1'b0, dump_req: 1'b0, done: 1'b0, cmd_ready: 1'b0};
        case (st)
            ST_IDLE: o.cmd_ready = 1'b1;
            ST_RUN: begin
                o.mode      = CONT_MOD;
                o.cmd_ready = 1'b1;
            end
            ST_STEP: begin
                o.mode    = STEP_MOD;
                o.execute = 1'b1;
            end
            ST_DUMP: o.dump_req = 1'b1;
            ST_DONE: begin
                o.done      = 1'b1;
                o.cmd_ready = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pipeline_exec_ctrl_if.sv
// Debug-unit link: command handshake toward the controller and dump request/ack back.
// The controller takes the slave side; the debug unit drives the master side.
interface pipeline_exec_ctrl_if;
    import pipeline_ctrl_pkg::*;

    logic i_cmd_valid;
    cmd_e i_cmd;
    logic o_cmd_ready;
    logic o_dump_req;
    logic i_dump_ack;

    modport master (
        output i_cmd_valid, i_cmd, i_dump_ack,
        input  o_cmd_ready, o_dump_req
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_dump_ack,
        output o_cmd_ready, o_dump_req
    );
endinterface

// File: rtl/pipeline_exec_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
// Latency: count visible the cycle after an enabled edge.
// Backpressure: none, free-running when enabled.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_count <= '0;
        end else if (i_en && (o_count != '1)) begin
            o_count <= o_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Turns debug run/step/halt commands into latch mode/advance controls, drains on EOF.
// Latency: accepted command drives mode/execute on the next cycle; all outputs registered.
// Backpressure: cmd_ready low in STEP and DUMP; dump_req held until dump_ack.
module pipeline_exec_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB_CYCLE_CNT = 32,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    pipeline_exec_ctrl_if.slave     dbg,
    input  logic                    i_eof_flag,
    output logic [1:0]              o_pipeline_mode,
    output logic                    o_execute_instruct,
    output logic [NB_CYCLE_CNT-1:0] o_cycle_count,
    output logic                    o_done,
    output logic [2:0]              o_state
);

    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES);

    state_e              state;
    ctrl_out_t           outs;
    logic                eof_seen;
    logic [NB_DRAIN-1:0] drain_cnt;
    logic [NB_DRAIN-1:0] drain_nxt;
    logic                advancing;
    logic                eof_first;
    logic                finished;
    logic                cmd_take;

    assign advancing = (state == ST_RUN) || (state == ST_STEP);
    assign eof_first = i_eof_flag && !eof_seen;
    assign cmd_take  = dbg.i_cmd_valid && outs.cmd_ready;

    // Finished looks at the count after this cycle's update, so the final
    // drain cycle and the EOF cycle itself can both end the program.
    always_comb begin
        drain_nxt = drain_cnt;
        if (eof_first) begin
            drain_nxt = DRAIN_LOAD;
        end else if (advancing && eof_seen && (drain_cnt != '0)) begin
            drain_nxt = drain_cnt - NB_DRAIN'(1);
        end
    end

    assign finished = (eof_seen || eof_first) && (drain_nxt == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            outs      <= state_outputs(ST_IDLE);
            eof_seen  <= 1'b0;
            drain_cnt <= '0;
        end else begin
            eof_seen  <= eof_seen | i_eof_flag;
            drain_cnt <= drain_nxt;
            case (state)
                ST_IDLE: begin
                    if (cmd_take && (dbg.i_cmd == CMD_RUN)) begin
                        state <= ST_RUN;
                        outs  <= state_outputs(ST_RUN);
                    end else if (cmd_take && (dbg.i_cmd == CMD_STEP)) begin
                        state <= ST_STEP;
                        outs  <= state_outputs(ST_STEP);
                    end
                end
                ST_RUN: begin
                    if (finished || (cmd_take && (dbg.i_cmd == CMD_HALT))) begin
                        state <= ST_DUMP;
                        outs  <= state_outputs(ST_DUMP);
                    end
                end
                ST_STEP: begin
                    state <= ST_DUMP;
                    outs  <= state_outputs(ST_DUMP);
                end
                ST_DUMP: begin
                    if (dbg.i_dump_ack) begin
                        state <= finished ? ST_DONE : ST_IDLE;
                        outs  <= state_outputs(finished ? ST_DONE : ST_IDLE);
                    end
                end
                ST_DONE: ;
                default: begin
                    state <= ST_IDLE;
                    outs  <= state_outputs(ST_IDLE);
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (NB_CYCLE_CNT)
    ) u_cycle_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (advancing),
        .o_count (o_cycle_count)
    );

    assign o_pipeline_mode    = outs.mode;
    assign o_execute_instruct = outs.execute;
    assign o_done             = outs.done;
    assign o_state            = state;
    assign dbg.o_cmd_ready    = outs.cmd_ready;
    assign dbg.o_dump_req     = outs.dump_req;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Bench for pipeline_exec_ctrl: four parameter sets share one stimulus stream,
// each with its own reference model feeding a per-cycle scoreboard.
module tb_pipeline_exec_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int NCFG = 4;
    localparam int CFG_DRAIN [NCFG] = '{1, 2, 0, 1};
    localparam int CFG_NB    [NCFG] = '{32, 32, 32, 4};

    typedef enum int {M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DUMP = 3, M_DONE = 4} mstate_e;

    typedef struct packed {
        logic [2:0]  st;
        logic [1:0]  mode;
        logic        exec;
        logic        dump_req;
        logic        done;
        logic        ready;
        logic [31:0] cnt;
    } obs_t;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic cmd_valid = 1'b0;
    cmd_e cmd       = CMD_NOP;
    logic dump_ack  = 1'b0;
    logic eof       = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic obs_t expect_of(mstate_e ph, longint cyc);
        obs_t e;
        e          = '0;
        e.st       = 3'(int'(ph));
        e.mode     = (ph == M_RUN) ? 2'b01 : (ph == M_STEP) ? 2'b11 : 2'b00;
        e.exec     = (ph == M_STEP);
        e.dump_req = (ph == M_DUMP);
        e.done     = (ph == M_DONE);
        e.ready    = (ph == M_IDLE) || (ph == M_RUN) || (ph == M_DONE);
        e.cnt      = 32'(cyc);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int     D    = CFG_DRAIN[g];
        localparam int     NB   = CFG_NB[g];
        localparam longint CMAX = (longint'(1) << NB) - 1;

        pipeline_exec_ctrl_if dbg ();
        logic [1:0]    mode;
        logic          exec;
        logic [NB-1:0] cnt;
        logic          done;
        logic [2:0]    st;

        assign dbg.i_cmd_valid = cmd_valid;
        assign dbg.i_cmd       = cmd;
        assign dbg.i_dump_ack  = dump_ack;

        pipeline_exec_ctrl #(
            .NB_CYCLE_CNT (NB),
            .DRAIN_CYCLES (D)
        ) dut (
            .i_clk              (clk),
            .i_reset            (rst),
            .dbg                (dbg.slave),
            .i_eof_flag         (eof),
            .o_pipeline_mode    (mode),
            .o_execute_instruct (exec),
            .o_cycle_count      (cnt),
            .o_done             (done),
            .o_state            (st)
        );

        // Reference: finished once EOF is known and at least D advancing
        // cycles have elapsed after the cycle that first saw it.
        mstate_e ph = M_IDLE;
        bit      eof_seen;
        int      adv_since;
        longint  cyc;
        bit      adv, fin, take;
        obs_t    q[$];
        obs_t    act, e;

        always @(posedge clk) begin
            if (rst) begin
                ph        = M_IDLE;
                eof_seen  = 1'b0;
                adv_since = 0;
                cyc       = 0;
            end else begin
                adv = (ph == M_RUN) || (ph == M_STEP);
                if (eof_seen && adv) adv_since++;
                if (!eof_seen && eof) begin
                    eof_seen  = 1'b1;
                    adv_since = 0;
                end
                fin = eof_seen && (adv_since >= D);
                if (adv && (cyc < CMAX)) cyc++;
                take = cmd_valid && ((ph == M_IDLE) || (ph == M_RUN) || (ph == M_DONE));
                case (ph)
                    M_IDLE: begin
                        if (take && cmd == CMD_RUN) ph = M_RUN;
                        else if (take && cmd == CMD_STEP) ph = M_STEP;
                    end
                    M_RUN:  if (fin || (take && cmd == CMD_HALT)) ph = M_DUMP;
                    M_STEP: ph = M_DUMP;
                    M_DUMP: if (dump_ack) ph = fin ? M_DONE : M_IDLE;
                    default: ;
                endcase
            end
            q.push_back(expect_of(ph, cyc));
        end

        always @(negedge clk) begin
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {st, mode, exec, dbg.o_dump_req, done, dbg.o_cmd_ready, 32'(cnt)};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL cfg%0d outputs @%0t: got st=%0d mode=%b exec=%b dreq=%b done=%b rdy=%b cnt=%0d, expected st=%0d mode=%b exec=%b dreq=%b done=%b rdy=%b cnt=%0d",
                             g, $time, act.st, act.mode, act.exec, act.dump_req, act.done, act.ready, act.cnt,
                             e.st, e.mode, e.exec, e.dump_req, e.done, e.ready, e.cnt);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input cmd_e c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick(1);
        cmd_valid = 1'b0;
        cmd       = CMD_NOP;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("reset_state", 64'(g_cfg[0].st), 64'd0);
        chk("reset_ready", 64'(g_cfg[0].dbg.o_cmd_ready), 64'd1);
        rst = 1'b0;
        tick(2);

        // Single step, then dump handshake
        send(CMD_STEP);
        chk("step_mode", 64'(g_cfg[0].mode), 64'd3);
        chk("step_exec", 64'(g_cfg[0].exec), 64'd1);
        tick(1);
        chk("step_dump_req", 64'(g_cfg[0].dbg.o_dump_req), 64'd1);
        chk("step_exec_low", 64'(g_cfg[0].exec), 64'd0);
        tick(1);
        dump_ack = 1'b1;
        tick(1);
        dump_ack = 1'b0;
        chk("step_ack_idle", 64'(g_cfg[0].st), 64'd0);
        chk("step_cnt", 64'(g_cfg[0].cnt), 64'd1);

        // RUN with EOF pulse, DRAIN_CYCLES = 1
        send(CMD_RUN);
        tick(3);
        eof = 1'b1;
        tick(1);
        eof = 1'b0;
        chk("drain_mode_k1", 64'(g_cfg[0].mode), 64'd1);
        tick(1);
        chk("drain_dump_k2", 64'(g_cfg[0].st), 64'd3);
        dump_ack = 1'b1;
        tick(1);
        dump_ack = 1'b0;
        chk("drain_done_state", 64'(g_cfg[0].st), 64'd4);
        chk("drain_done_flag", 64'(g_cfg[0].done), 64'd1);
        send(CMD_RUN);
        chk("done_run_dropped", 64'(g_cfg[0].mode), 64'd0);
        do_reset();
        chk("rst_cnt", 64'(g_cfg[0].cnt), 64'd0);

        // HALT and resume
        send(CMD_RUN);
        tick(3);
        send(CMD_HALT);
        chk("halt_dump", 64'(g_cfg[0].st), 64'd3);
        chk("halt_cnt1", 64'(g_cfg[0].cnt), 64'd4);
        dump_ack = 1'b1;
        tick(1);
        dump_ack = 1'b0;
        chk("halt_idle", 64'(g_cfg[0].st), 64'd0);
        send(CMD_RUN);
        tick(3);
        send(CMD_HALT);
        dump_ack = 1'b1;
        tick(1);
        dump_ack = 1'b0;
        chk("resume_cnt", 64'(g_cfg[0].cnt), 64'd8);
        do_reset();

        // Step-mode EOF seen during DUMP, DRAIN_CYCLES = 2 (cfg1)
        send(CMD_STEP);
        tick(1);
        eof = 1'b1;
        tick(1);
        eof = 1'b0;
        dump_ack = 1'b1;
        tick(1);
        dump_ack = 1'b0;
        chk("stepeof_ack0", 64'(g_cfg[1].st), 64'd0);
        for (int s = 1; s <= 2; s++) begin
            send(CMD_STEP);
            tick(1);
            dump_ack = 1'b1;
            tick(1);
            dump_ack = 1'b0;
            chk($sformatf("stepeof_ack%0d", s), 64'(g_cfg[1].st), (s == 2) ? 64'd4 : 64'd0);
        end
        send(CMD_RUN);
        chk("stepeof_run_dropped", 64'(g_cfg[1].mode), 64'd0);
        do_reset();

        // HALT coincides with finish, DRAIN_CYCLES = 0 (cfg2)
        send(CMD_RUN);
        tick(2);
        cmd_valid = 1'b1;
        cmd       = CMD_HALT;
        eof       = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        cmd       = CMD_NOP;
        eof       = 1'b0;
        chk("coinc_dump", 64'(g_cfg[2].st), 64'd3);
        dump_ack = 1'b1;
        tick(1);
        dump_ack = 1'b0;
        chk("coinc_done", 64'(g_cfg[2].st), 64'd4);
        chk("coinc_cfg0_idle", 64'(g_cfg[0].st), 64'd0);

        // Reset while the dump request is pending, with a simultaneous ack
        send(CMD_STEP);
        tick(1);
        chk("pending_dump", 64'(g_cfg[0].dbg.o_dump_req), 64'd1);
        dump_ack = 1'b1;
        rst      = 1'b1;
        tick(1);
        rst      = 1'b0;
        dump_ack = 1'b0;
        chk("rst_dump_state", 64'(g_cfg[0].st), 64'd0);
        chk("rst_dump_req", 64'(g_cfg[0].dbg.o_dump_req), 64'd0);

        // Saturation with a 4-bit counter (cfg3)
        send(CMD_RUN);
        tick(20);
        chk("sat_cnt", 64'(g_cfg[3].cnt), 64'd15);
        chk("sat_mode", 64'(g_cfg[3].mode), 64'd1);
        do_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd       = cmd_e'($urandom_range(0, 3));
            dump_ack  = ($urandom_range(0, 3) == 0);
            eof       = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        cmd_valid = 1'b0;
        dump_ack  = 1'b0;
        eof       = 1'b0;
        rst       = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_exec_ctrl.md
# pipeline_exec_ctrl

Execution controller for the 5-stage pipeline debug flow. It turns debug-unit commands (run, step, halt) into the `pipeline_mode` / `execute_instruct` controls shared by all inter-stage latches. It detects end of program from the MEM/WB EOF flag and drains the pipeline before stopping. It hands off to the debug unit for a latch/register dump after every step, halt and program completion.

## Interface
- `NB_CYCLE_CNT`, 32: width of the advancing-cycle counter.
- `DRAIN_CYCLES`, 1: advancing cycles allowed after EOF is first sampled; range 0–15.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_cmd_valid` in 1: debug command valid.
- `i_cmd` in 2: command; 00 NOP, 01 RUN, 10 STEP, 11 HALT.
- `o_cmd_ready` in/out: out 1: command accepted on an edge where `i_cmd_valid && o_cmd_ready`.
- `i_eof_flag` in 1: EOF flag from the MEM/WB latch output.
- `o_pipeline_mode` out 2: 00 frozen, 01 continuous, 11 stepwise. Broadcast to all latches.
- `o_execute_instruct` out 1: one-cycle advance pulse in stepwise mode.
- `o_dump_req` out 1: request a debug dump; held until acknowledged.
- `i_dump_ack` in 1: dump complete.
- `o_cycle_count` out NB_CYCLE_CNT: number of advancing cycles since reset; saturating.
- `o_done` out 1: program finished; sticky until reset.
- `o_state` out 3: current FSM state, for debug readout.

## Operation
- **States**
  - IDLE = 0, RUN = 1, STEP = 2, DUMP = 3, DONE = 4.
  - RUN and STEP are the advancing states.
- **Per-state outputs**
  - IDLE: mode 00, ready 1.
  - RUN: mode 01, execute 0, ready 1.
  - STEP: mode 11, execute 1, ready 0.
  - DUMP: mode 00, `o_dump_req` 1, ready 0.
  - DONE: mode 00, `o_done` 1, ready 1.
- **IDLE transitions**
  - RUN → RUN.
  - STEP → STEP.
  - HALT and NOP are accepted with no effect.
- **RUN transitions**
  - HALT → DUMP, then IDLE.
  - RUN, STEP and NOP are accepted and dropped.
  - Program finished → DUMP, then DONE.
- **STEP:** lasts exactly one cycle, then → DUMP.
- **DUMP:** on an edge with `i_dump_ack` = 1 → DONE if the program is finished, else IDLE. `i_dump_ack` is ignored in every other state.
- **DONE:** all commands are accepted and dropped. Only reset leaves DONE.
- **EOF tracking**
  - `eof_seen` is set the first time `i_eof_flag` is sampled high, in any state. At the same time the drain counter loads `DRAIN_CYCLES`.
  - Each advancing cycle after that decrements the drain counter, saturating at 0.
  - Finished means `eof_seen` is set and the drain counter is 0. The finished test includes the cycle in which `eof_seen` is set.
- **Priority:** if finish and HALT coincide in RUN, finish wins (DUMP → DONE).
- **Drain counter width:** 4 bits.
- **Cycle counter:** increments once per cycle spent in RUN or STEP; stays at all-ones once saturated.

## Timing
- All outputs are registered or decoded from the state register only; there are no combinational input-to-output paths.
- **Reset values:**
  - state IDLE; `o_state` 0.
  - `o_pipeline_mode` 00, `o_execute_instruct` 0.
  - `o_dump_req` 0, `o_done` 0, `o_cmd_ready` 1.
  - `o_cycle_count` 0, `eof_seen` 0, drain counter 0.
- **Command latency:** a command accepted on edge N drives its mode/execute values in cycle N+1.
- **Step:** `o_execute_instruct` is high for exactly cycle N+1. `o_dump_req` rises in N+2.
- **RUN drain:** EOF is first sampled high in RUN during cycle k. Mode stays 01 through cycle k+`DRAIN_CYCLES`. DUMP is entered in cycle k+`DRAIN_CYCLES`+1.
- **Step-mode EOF:** EOF seen during DUMP or IDLE is counted down by subsequent STEPs. The dump following the step that zeroes the counter exits to DONE.
- **Dump exit:** ack sampled on edge M → the next state is effective in cycle M+1. Ack in the first DUMP cycle is legal.
- **Reset mid-operation:** reset during any state, including DUMP with the request pending, returns to reset values on the next edge. Reset overrides any simultaneous command or ack.

## Structure
- **Package `pipeline_ctrl_pkg`:**
  - mode constants FREEZE_MOD = 2'b00, CONT_MOD = 2'b01, STEP_MOD = 2'b11.
  - command encodings.
  - FSM state encodings.
- The latch modules import the mode constants from this package.
- **Sub-module `sat_counter`** (parameterised width, `i_en`, synchronous reset) implements the cycle counter. The drain counter is inline.

## Test plan
- Reset, then STEP accepted at edge 5 → cycle 6: mode 11, execute 1; cycle 7: `o_dump_req` 1; ack at edge 9 → IDLE; `o_cycle_count` = 1.
- RUN accepted, `i_eof_flag` pulsed at cycle 20, `DRAIN_CYCLES` = 1 → mode 01 through cycle 21, DUMP at 22; after ack → DONE, `o_done` 1.
- RUN, then HALT at edge 30 → DUMP at 31, ack → IDLE. A second RUN resumes and `o_cycle_count` continues from its prior value.
- Step mode with EOF first seen during DUMP, `DRAIN_CYCLES` = 2 → second following STEP's dump exits to DONE; a later RUN is dropped and mode stays 00.
- HALT and EOF finish coincide in RUN (`DRAIN_CYCLES` = 0) → DUMP then DONE. Reset asserted while in DUMP → next cycle state 0, `o_dump_req` 0.
- `NB_CYCLE_CNT` = 4, RUN for 20 cycles → `o_cycle_count` saturates at 15.
